// File: rtl/fp_decoder_pkg.sv
// Shared definitions for the float-to-linear decoder.
// Holds the default field widths, the bit positions of the fields inside
// the 8-bit float code, and the 2-bit state encoding of the shift FSM.
package fpcvt_pkg;

  localparam int EXP_W  = 3;
  localparam int SIG_W  = 4;
  localparam int OUT_W  = 12;
  localparam int CODE_W = 1 + EXP_W + SIG_W;

  // Field positions inside the code {sign, exp, sig}
  localparam int SIGN_BIT = EXP_W + SIG_W;
  localparam int EXP_MSB  = EXP_W + SIG_W - 1;
  localparam int EXP_LSB  = SIG_W;
  localparam int SIG_MSB  = SIG_W - 1;
  localparam int SIG_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : fpcvt_pkg

// File: rtl/fp_decoder_if.sv
// Stream interface of the float-to-linear decoder.
// Input side : in (float code), in_valid, in_ready.
// Output side: out (linear two's-complement value), out_valid, out_ready.
// master = producer/consumer environment, slave = the decoder.
interface fp_decoder_if
  import fpcvt_pkg::*;
#(
  parameter int P_EXP_W = EXP_W,
  parameter int P_SIG_W = SIG_W,
  parameter int P_OUT_W = OUT_W
);

  logic [P_EXP_W+P_SIG_W:0] in;
  logic                     in_valid;
  logic                     in_ready;
  logic [P_OUT_W-1:0]       out;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in,
    output in_valid,
    input  in_ready,
    input  out,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in,
    input  in_valid,
    output in_ready,
    output out,
    output out_valid,
    input  out_ready
  );

endinterface : fp_decoder_if

// File: rtl/fp_decoder_sm_to_tc.sv
// Combinational sign-magnitude to two's-complement conversion.
// Ports: sign   - 1 means negative
//        mag    - unsigned magnitude, OUT_W-1 bits
//        tc     - OUT_W-bit two's-complement result
// A zero magnitude always gives 0, so a negative zero never shows up as
// the most negative code.
module sm_to_tc
  import fpcvt_pkg::*;
#(
  parameter int P_OUT_W = OUT_W
) (
  input  logic               sign,
  input  logic [P_OUT_W-2:0] mag,
  output logic [P_OUT_W-1:0] tc
);

  logic [P_OUT_W-1:0] mag_ext_s;

  assign mag_ext_s = {1'b0, mag};

  // Negate via invert-plus-one; zero magnitude forced to zero explicitly
  always_comb begin
    tc = {P_OUT_W{1'b0}};
    if (mag == {(P_OUT_W-1){1'b0}}) begin
      tc = {P_OUT_W{1'b0}};
    end else if (sign) begin
      tc = (~mag_ext_s) + {{(P_OUT_W-1){1'b0}}, 1'b1};
    end else begin
      tc = mag_ext_s;
    end
  end

endmodule : sm_to_tc

// File: rtl/fp_decoder.sv
// Float-to-linear decoder.
// Converts an 8-bit float code {sign, exp, sig} into an OUT_W-bit
// two's-complement value (sig << exp, negated when sign is set) using a
// one-bit-per-cycle shifter.
// Ports: clk   - rising-edge clock
//        rst_n - asynchronous active-low reset
//        bus   - fp_decoder_if.slave: in/in_valid/in_ready on the input side,
//                out/out_valid/out_ready on the output side
// Timing: a code accepted in cycle k yields out_valid in cycle k+exp+2.
// All outputs come straight from registers, so there is no combinational
// path from the input side to the output side or from out_ready to in_ready.
module fp_decoder
  import fpcvt_pkg::*;
#(
  parameter int P_EXP_W = EXP_W,
  parameter int P_SIG_W = SIG_W,
  parameter int P_OUT_W = OUT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_decoder_if.slave  bus
);

  localparam int L_SIGN_BIT = P_EXP_W + P_SIG_W;
  localparam int L_EXP_LSB  = P_SIG_W;
  localparam int L_MAG_W    = P_OUT_W - 1;

  // Largest shift must never push a set bit out of the magnitude register
  if (P_OUT_W < P_SIG_W + (1 << P_EXP_W)) begin : g_width_check
    $error("fp_decoder: OUT_W too small for SIG_W and EXP_W");
  end

  state_e               state_r;
  logic                 sign_r;
  logic [P_EXP_W-1:0]   cnt_r;
  logic [L_MAG_W-1:0]   mag_r;
  logic [P_OUT_W-1:0]   out_r;
  logic                 out_valid_r;
  logic                 in_ready_r;
  logic [P_OUT_W-1:0]   tc_s;

  sm_to_tc #(
    .P_OUT_W (P_OUT_W)
  ) u_sm_to_tc (
    .sign (sign_r),
    .mag  (mag_r),
    .tc   (tc_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;

  // Control FSM, shifter datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      sign_r      <= 1'b0;
      cnt_r       <= {P_EXP_W{1'b0}};
      mag_r       <= {L_MAG_W{1'b0}};
      out_r       <= {P_OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // in_ready_r is always 1 here, so in_valid alone is the handshake
          if (bus.in_valid) begin
            sign_r     <= bus.in[L_SIGN_BIT];
            cnt_r      <= bus.in[L_SIGN_BIT-1:L_EXP_LSB];
            mag_r      <= {{(L_MAG_W-P_SIG_W){1'b0}}, bus.in[P_SIG_W-1:0]};
            in_ready_r <= 1'b0;
            state_r    <= ST_SHIFT;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // sig=0 still walks through all exp steps to keep latency fixed
          if (cnt_r != {P_EXP_W{1'b0}}) begin
            mag_r <= {mag_r[L_MAG_W-2:0], 1'b0};
            cnt_r <= cnt_r - {{(P_EXP_W-1){1'b0}}, 1'b1};
          end else begin
            out_r       <= tc_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // out is left untouched after the handshake; only out_valid drops
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : fp_decoder

// File: tb/tb_fp_decoder.sv
// Self-checking bench for fp_decoder: a table of directed vectors with
// hand-computed results, hand-written stall/reset sequences, and a sweep of
// all 256 codes against a small reference model.
module tb_fp_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fp_decoder_if #(.P_EXP_W(3), .P_SIG_W(4), .P_OUT_W(12)) bus ();

  fp_decoder #(.P_EXP_W(3), .P_SIG_W(4), .P_OUT_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic [11:0] exp_out;
    int          lat;
    int          stall;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] ref_val(input logic [7:0] code);
    logic [11:0] m;
    m = {8'd0, code[3:0]} << code[6:4];
    ref_val = code[7] ? (12'd0 - m) : m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one code, measure latency, hold the result for 'stall' cycles, then drain it
  task automatic convert(input logic [7:0] code, input logic [11:0] exp_out,
                         input int exp_lat, input int stall, input string name);
    int n;
    bus.in       = code;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      chk({name, "_in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
      step();
      n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_out"}, {20'd0, bus.out}, {20'd0, exp_out});
    for (int i = 0; i < stall; i++) begin
      step();
      chk({name, "_hold_out"}, {20'd0, bus.out}, {20'd0, exp_out});
      chk({name, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({name, "_drain_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "_drain_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    bus.in        = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    vecs[0] = '{code: 8'h00, exp_out: 12'h000, lat: 2, stall: 0};
    vecs[1] = '{code: 8'h7F, exp_out: 12'h780, lat: 9, stall: 0};
    vecs[2] = '{code: 8'hFF, exp_out: 12'h880, lat: 9, stall: 1};
    vecs[3] = '{code: 8'h80, exp_out: 12'h000, lat: 2, stall: 0};
    vecs[4] = '{code: 8'h90, exp_out: 12'h000, lat: 3, stall: 0};
    vecs[5] = '{code: 8'h01, exp_out: 12'h001, lat: 2, stall: 0};
    vecs[6] = '{code: 8'h9F, exp_out: 12'hFE2, lat: 3, stall: 2};
    vecs[7] = '{code: 8'h4A, exp_out: 12'h0A0, lat: 6, stall: 0};

    // Reset state, with inputs wiggling that must be ignored
    bus.in_valid = 1'b1;
    bus.in       = 8'h7F;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {20'd0, bus.out}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].code, vecs[i].exp_out, vecs[i].lat, vecs[i].stall,
              $sformatf("vec%0d", i));
    end

    // 0x35 held for 5 cycles while a second code is offered and must be ignored
    bus.in       = 8'h35;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("stall_first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stall_out", {20'd0, bus.out}, 32'h028);
    bus.in       = 8'hFF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_out", {20'd0, bus.out}, 32'h028);
      chk("stall_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("stall_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (3) step();
    chk("stall_no_capture", {31'd0, bus.out_valid}, 32'd0);
    chk("stall_out_kept", {20'd0, bus.out}, 32'h028);

    // Leave a nonzero out so the reset-clear is visible
    convert(8'h7F, 12'h780, 9, 0, "pre_rst");

    // Reset asserted mid-cycle in the 4th SHIFT cycle of 0x7F
    bus.in       = 8'h7F;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_out", {20'd0, bus.out}, 32'd0);
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    convert(8'hA3, 12'hFF4, 4, 0, "post_rst");

    // All 256 codes against the reference model with random stalls
    for (int c = 0; c < 256; c++) begin
      logic [7:0] code;
      code = c[7:0];
      convert(code, ref_val(code), int'(code[6:4]) + 2, $urandom_range(0, 3),
              $sformatf("sweep_%02h", code));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fp_decoder

// File: doc/fp_decoder.md
Name: fp_decoder

Overview:
- Inverse of the linear-to-float converter path: takes the 8-bit floating-point code {sign, exp[2:0], sig[3:0]} and reconstructs the 12-bit two's-complement linear value.
- Magnitude is sig << exp, with sign applied afterwards.
- Multi-cycle, one-bit-per-cycle shifter with valid/ready handshakes on both sides. Sits between the float sample stream and linear-domain consumers (DAC/accumulator side).

Parameters:
EXP_W, 3, exponent field width
SIG_W, 4, significand field width
OUT_W, 12, linear output width; must satisfy OUT_W >= SIG_W + 2**EXP_W (checked by elaboration assertion)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in  input  1+EXP_W+SIG_W  float code: [7] sign, [6:4] exp, [3:0] sig
in_valid  input  1  in holds a code to convert
in_ready  output  1  block can accept a code
out  output  OUT_W  linear two's-complement result
out_valid  output  1  out holds a completed result
out_ready  input  1  consumer accepts out

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values while rst_n low:
  - State IDLE; out=0, out_valid=0; internal mag/cnt/sign cleared.
  - in_ready = (state==IDLE), so it reads 1 during reset. Inputs are ignored while rst_n is low.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: capture sign, cnt<=exp, mag<=zero-extended sig (OUT_W-1 bits); go to SHIFT.
- State SHIFT:
  - in_ready=0.
  - If cnt!=0: mag<=mag<<1, cnt<=cnt-1.
  - If cnt==0: out<=sign ? -mag : mag (two's complement, OUT_W bits); out_valid<=1; go to DONE.
- State DONE:
  - out_valid=1; out and out_valid hold stable until out_ready.
  - On out_ready: out_valid<=0, go to IDLE. out keeps its last value (don't-care while out_valid=0).
- Latency: if the input handshake occurs in cycle k, out_valid is first high in cycle k+E+2 (E = exp).
- Throughput: no bypass from DONE to IDLE; minimum spacing is E+3 cycles per code.
- Arithmetic: maximum magnitude is 15<<7 = 1920, so no overflow occurs at default widths. Shifting never drops set bits when OUT_W meets the constraint.
- Negative zero (sign=1, sig=0): output is 0x000, never 0x800.
- sig=0 with any exp: output is 0; SHIFT still runs E cycles, so latency is unchanged.
- in_valid asserted while not in IDLE: ignored, not captured; the producer must hold it.
- Reset asserted mid-SHIFT or in DONE: the conversion is abandoned and all reset values apply at once. After rst_n rises, the first edge can accept a new code.
- No combinational path from in/in_valid to out/out_valid, or from out_ready to in_ready within the same cycle.

Decomposition:
- Shared package fpcvt_pkg holds:
  - EXP_W/SIG_W/OUT_W defaults
  - field-slice localparams: SIGN_BIT, EXP_MSB/LSB, SIG_MSB/LSB
  - state encoding IDLE/SHIFT/DONE (2-bit)
- One sub-module, sm_to_tc: combinational sign-magnitude to two's-complement conversion.
  - Inputs: sign, mag[OUT_W-2:0]; output: OUT_W bits.
  - Zero magnitude always yields 0.
  - Instantiated in the SHIFT-to-DONE output-register path.

Test Plan:
- Reset, then in=0x00 with out_ready=1 -> out=0x000; out_valid first high exactly 2 cycles after the handshake cycle; in_ready back to 1 the cycle after the out handshake.
- in=0x7F (exp7, sig15) -> out=0x780 (1920), latency 9. in=0xFF -> out=0x880 (-1920), latency 9.
- in=0x80 (negative zero) -> out=0x000; in=0x90 (sign1, exp1, sig0) -> out=0x000, latency 3.
- in=0x35 (exp3, sig5), out_ready held 0 for 5 cycles after out_valid -> out=0x028 stable; out_valid=1 and in_ready=0 throughout. A second in_valid presented during that window is not captured. Release out_ready -> in_ready=1 next cycle.
- Start in=0x7F, pull rst_n low asynchronously in the 4th SHIFT cycle (mid-cycle) -> out_valid=0 and out=0x000 immediately. After release, in=0xA3 (sign1, exp2, sig3) -> out=0xFF4 (-12), latency 4.
- Sweep all 256 codes back-to-back with random out_ready stalls -> each out equals the reference model (sign ? -(sig<<exp) : sig<<exp) mod 4096. No dropped or duplicated results; latency exactly E+2 every time.
